// File: rtl/stream_adder_pkg.sv
// Shared op encodings and saturation-bound helpers for the stream adder.
// Latency: none (package only).
// Backpressure: not applicable.
package stream_adder_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    // Helpers return a wide vector; callers keep the low WIDTH bits.
    localparam int SAT_MAX_W = 256;

    function automatic logic [SAT_MAX_W-1:0] sat_max(input int width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i < width - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i == width - 1) begin
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_pipe_reg.sv
// Single valid/ready register slice carrying an opaque DW-bit payload.
// Latency: 1 cycle; full throughput.
// Backpressure: in_ready = !out_valid || out_ready (combinational pass-through of out_ready).
module adder_pipe_reg #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/stream_adder_acc.sv
// Two-operand add/sub/accumulate unit with optional signed saturation and term counter.
// Latency: 2 cycles accept-to-out_valid; 1 beat/cycle throughput.
// Backpressure: in_ready falls only when both stages are full and out_ready is low.
module stream_adder_acc
    import stream_adder_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic [CNT_W-1:0] acc_cnt
);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } res_t;

    localparam int DW = $bits(res_t);

    localparam logic [SAT_MAX_W-1:0] SAT_MAX_FULL = sat_max(WIDTH);
    localparam logic [SAT_MAX_W-1:0] SAT_MIN_FULL = sat_min(WIDTH);
    localparam logic [WIDTH-1:0]     SAT_MAX      = SAT_MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SAT_MIN      = SAT_MIN_FULL[WIDTH-1:0];
    localparam logic [CNT_W-1:0]     CNT_MAX      = '1;

    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] res;
    logic             carry_c;
    logic             ovf_c;
    logic             first_neg;

    logic             accept;
    logic             s1_valid;
    logic             s2_ready;
    res_t             s1_in;
    res_t             s1_out;
    res_t             s2_out;

    assign accept = in_valid && in_ready;

    // Raw arithmetic is one bit wider so the MSB is carry (ADD/ACC) or borrow (SUB).
    always_comb begin
        raw       = '0;
        carry_c   = 1'b0;
        ovf_c     = 1'b0;
        first_neg = a[WIDTH-1];
        case (op)
            OP_ADD: begin
                raw     = {1'b0, a} + {1'b0, b};
                carry_c = raw[WIDTH];
                ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                raw     = {1'b0, a} - {1'b0, b};
                carry_c = raw[WIDTH];
                ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ACC: begin
                first_neg = acc[WIDTH-1];
                raw       = {1'b0, acc} + {1'b0, a};
                carry_c   = raw[WIDTH];
                ovf_c     = (acc[WIDTH-1] == a[WIDTH-1]) && (raw[WIDTH-1] != acc[WIDTH-1]);
            end
            default: begin
                raw = {1'b0, a};
            end
        endcase
    end

    always_comb begin
        res = raw[WIDTH-1:0];
        if ((SATURATE != 0) && ovf_c) begin
            res = first_neg ? SAT_MIN : SAT_MAX;
        end
    end

    always_comb begin
        acc_nxt = acc;
        cnt_nxt = cnt;
        case (op)
            OP_ACC: begin
                acc_nxt = res;
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            end
            OP_CLR: begin
                acc_nxt = a;
                cnt_nxt = CNT_W'(1);
            end
            default: begin
                acc_nxt = acc;
                cnt_nxt = cnt;
            end
        endcase
    end

    // Accumulator advances at accept, so a following ACC beat sees the new value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end

    always_comb begin
        s1_in.sum   = res;
        s1_in.carry = carry_c;
        s1_in.ovf   = ovf_c;
        s1_in.cnt   = cnt_nxt;
    end

    adder_pipe_reg #(
        .DW (DW)
    ) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    adder_pipe_reg #(
        .DW (DW)
    ) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s1_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign sum     = s2_out.sum;
    assign carry   = s2_out.carry;
    assign ovf     = s2_out.ovf;
    assign acc_cnt = s2_out.cnt;

endmodule

// File: tb/tb_stream_adder_acc.sv
// Directed bench driving a wrapping and a saturating instance with identical stimulus.
module tb_stream_adder_acc;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;

    logic       d0_in_ready, d0_out_valid, d0_carry, d0_ovf;
    logic [7:0] d0_sum, d0_acc_cnt;
    logic       d1_in_ready, d1_out_valid, d1_carry, d1_ovf;
    logic [7:0] d1_sum, d1_acc_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    stream_adder_acc #(.WIDTH(8), .SATURATE(0), .CNT_W(8)) d0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d0_in_ready),
        .a(a), .b(b), .op(op), .out_valid(d0_out_valid), .out_ready(out_ready),
        .sum(d0_sum), .carry(d0_carry), .ovf(d0_ovf), .acc_cnt(d0_acc_cnt)
    );

    stream_adder_acc #(.WIDTH(8), .SATURATE(1), .CNT_W(8)) d1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(d1_in_ready),
        .a(a), .b(b), .op(op), .out_valid(d1_out_valid), .out_ready(out_ready),
        .sum(d1_sum), .carry(d1_carry), .ovf(d1_ovf), .acc_cnt(d1_acc_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated beat with out_ready high; expected values written per instance.
    task automatic run_one(input string tag, input logic [1:0] o, input logic [7:0] av,
                           input logic [7:0] bv, input logic [7:0] e0_sum,
                           input logic [7:0] e1_sum, input logic e_carry,
                           input logic e_ovf, input logic [7:0] e_cnt);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_lat"}, 32'(d0_out_valid), 32'h0);
        @(negedge clk);
        chk({tag, "_vld0"},   32'(d0_out_valid), 32'h1);
        chk({tag, "_sum0"},   32'(d0_sum),       32'(e0_sum));
        chk({tag, "_carry0"}, 32'(d0_carry),     32'(e_carry));
        chk({tag, "_ovf0"},   32'(d0_ovf),       32'(e_ovf));
        chk({tag, "_cnt0"},   32'(d0_acc_cnt),   32'(e_cnt));
        chk({tag, "_vld1"},   32'(d1_out_valid), 32'h1);
        chk({tag, "_sum1"},   32'(d1_sum),       32'(e1_sum));
        chk({tag, "_carry1"}, 32'(d1_carry),     32'(e_carry));
        chk({tag, "_ovf1"},   32'(d1_ovf),       32'(e_ovf));
    endtask

    logic [7:0] got [4];
    int         nacc;
    int         ngot;

    initial begin
        clk = 1'b0; reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; op = 2'b00;
        for (int i = 0; i < 4; i++) got[i] = 8'h00;

        // Reset state
        #12;
        chk("rst_vld",   32'(d0_out_valid), 32'h0);
        chk("rst_sum",   32'(d0_sum),       32'h0);
        chk("rst_carry", 32'(d0_carry),     32'h0);
        chk("rst_ovf",   32'(d0_ovf),       32'h0);
        chk("rst_cnt",   32'(d0_acc_cnt),   32'h0);
        chk("rst_rdy",   32'(d0_in_ready),  32'h1);
        chk("rst_vld1",  32'(d1_out_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        run_one("add_carry", 2'b00, 8'hF0, 8'h20, 8'h10, 8'h10, 1'b1, 1'b0, 8'd0);
        run_one("add_ovf",   2'b00, 8'h7F, 8'h01, 8'h80, 8'h7F, 1'b0, 1'b1, 8'd0);
        run_one("sub_borrow", 2'b01, 8'h05, 8'h07, 8'hFE, 8'hFE, 1'b1, 1'b0, 8'd0);
        run_one("sub_ovf",   2'b01, 8'h80, 8'h01, 8'h7F, 8'h80, 1'b0, 1'b1, 8'd0);

        // CLR then two ACC beats back to back
        @(negedge clk);
        op = 2'b11; a = 8'h03; b = 8'hAA; in_valid = 1'b1;
        @(negedge clk);
        op = 2'b10; a = 8'h04;
        @(negedge clk);
        chk("clr_sum",  32'(d0_sum),     32'h03);
        chk("clr_cnt",  32'(d0_acc_cnt), 32'd1);
        chk("clr_vld",  32'(d0_out_valid), 32'h1);
        op = 2'b10; a = 8'h05;
        @(negedge clk);
        in_valid = 1'b0;
        chk("acc1_sum",  32'(d0_sum),     32'h07);
        chk("acc1_cnt",  32'(d0_acc_cnt), 32'd2);
        chk("acc1_sum1", 32'(d1_sum),     32'h07);
        @(negedge clk);
        chk("acc2_sum",  32'(d0_sum),     32'h0C);
        chk("acc2_cnt",  32'(d0_acc_cnt), 32'd3);
        chk("acc2_sum1", 32'(d1_sum),     32'h0C);
        chk("acc2_cnt1", 32'(d1_acc_cnt), 32'd3);

        run_one("add_after_acc", 2'b00, 8'h01, 8'h01, 8'h02, 8'h02, 1'b0, 1'b0, 8'd3);

        // Downstream stalled for 5 cycles while 4 beats are offered
        @(negedge clk);
        out_ready = 1'b0; op = 2'b00; b = 8'h01; in_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            a = 8'h10 + 8'(nacc);
            if (i >= 2) begin
                chk($sformatf("stall_rdy%0d", i),  32'(d0_in_ready),  32'h0);
                chk($sformatf("stall_rdy1_%0d", i), 32'(d1_in_ready), 32'h0);
                chk($sformatf("stall_vld%0d", i),  32'(d0_out_valid), 32'h1);
                chk($sformatf("stall_sum%0d", i),  32'(d0_sum),       32'h11);
                chk($sformatf("stall_cnt%0d", i),  32'(d0_acc_cnt),   32'd3);
            end
            if (d0_in_ready) nacc++;
        end
        chk("stall_accepted", 32'(nacc), 32'd2);

        // Release: every beat must come out once, in order
        out_ready = 1'b1;
        #1;
        ngot = 0;
        for (int c = 0; c < 20 && ngot < 4; c++) begin
            if (d0_out_valid) begin
                got[ngot] = d0_sum;
                ngot++;
            end
            if (in_valid && d0_in_ready) nacc++;
            @(negedge clk);
            if (nacc < 4) a = 8'h10 + 8'(nacc);
            else          in_valid = 1'b0;
        end
        chk("drain_count", 32'(ngot), 32'd4);
        chk("drain_0", 32'(got[0]), 32'h11);
        chk("drain_1", 32'(got[1]), 32'h12);
        chk("drain_2", 32'(got[2]), 32'h13);
        chk("drain_3", 32'(got[3]), 32'h14);
        chk("drain_nodup", 32'(d0_out_valid), 32'h0);

        // Fill both stages, then reset asynchronously mid-cycle
        @(negedge clk);
        out_ready = 1'b0; op = 2'b10; a = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("full_vld", 32'(d0_out_valid), 32'h1);
        chk("full_rdy", 32'(d0_in_ready),  32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_vld",  32'(d0_out_valid), 32'h0);
        chk("arst_cnt",  32'(d0_acc_cnt),   32'h0);
        chk("arst_rdy",  32'(d0_in_ready),  32'h1);
        chk("arst_vld1", 32'(d1_out_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_vld", 32'(d0_out_valid), 32'h0);

        run_one("acc_after_rst", 2'b10, 8'h01, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_adder_acc.md
Name: stream_adder_acc

Overview:
- Parametrised successor to the team's registered two-operand adder.
- Adds ADD, SUB, running-accumulate and accumulator-load modes; optional signed saturation; carry and overflow flags; a term counter.
- valid/ready handshake on both sides with a 2-stage pipeline.
- Sits between an AXI-Lite/AXI-Stream front end and downstream consumers in the accelerator datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- SATURATE, 0, 0 = wrap-around arithmetic; 1 = clamp signed result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] on overflow.
- CNT_W, 8, width of accumulated-term counter.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset; all state cleared while low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B (ignored for ACC, CLR).
- op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- carry  out  1  unsigned carry-out (ADD/ACC) or borrow (SUB); 0 for CLR.
- ovf  out  1  signed overflow of the raw result; 0 for CLR.
- acc_cnt  out  CNT_W  terms in accumulator after this op.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Handshakes:
  - Input accepted when in_valid && in_ready.
  - Output transferred when out_valid && out_ready.
  - out_valid and output data are held stable until transferred.
- Stage 1 (s1): registers the computed result, flags and count on accept.
- Stage 2 (s2): output register driving sum/carry/ovf/acc_cnt/out_valid.
- Stall logic:
  - s2 loads when !out_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads (combinational from out_ready).
  - Full throughput of 1 beat/cycle.
- Latency: result appears on out_valid 2 cycles after accept when out_ready is held high.
- Arithmetic is computed at accept on a WIDTH+1 bit raw result:
  - ADD: a+b.
  - SUB: a-b; carry = borrow = (a<b unsigned).
  - ACC: acc+a.
  - CLR: result = a, flags 0.
  - ovf: operands of equal sign (ADD/ACC) or differing sign (SUB) with a result sign differing from the first operand.
- Saturation:
  - SATURATE=1 and ovf: result = max positive if the first operand is non-negative, else min negative.
  - ovf is still reported; carry is unaffected.
- Accumulator acc (WIDTH) and counter cnt (CNT_W) update at accept only:
  - CLR: acc=a, cnt=1.
  - ACC: acc=final (post-saturation) result, cnt=cnt+1, saturating at 2^CNT_W-1.
  - ADD/SUB: acc and cnt unchanged; acc_cnt output = current cnt.
- Back-to-back ACC beats use the acc value updated by the previous accept; no hazard.
- Reset values:
  - out_valid=0, sum=0, carry=0, ovf=0, acc_cnt=0.
  - s1_valid=0, acc=0, cnt=0.
  - in_ready=1 after reset (pipeline empty).
- Reset mid-operation: in-flight beats are discarded with no partial output, and the accumulator is lost.
- Simultaneous accept and transfer in the same cycle: both occur; no bubble and no duplication.
- Upstream must not assert in_valid while reset is low.

Decomposition:
- Shared package stream_adder_pkg holds:
  - op encoding constants OP_ADD/OP_SUB/OP_ACC/OP_CLR;
  - functions sat_max(WIDTH) and sat_min(WIDTH).
- One sub-module: adder_pipe_reg, a parametrised valid/ready register slice (data width param). It is instantiated for s1 and s2, each carrying {sum, carry, ovf, acc_cnt}.
- Arithmetic and acc/cnt logic stay in the top module.

Test Plan:
- WIDTH=8, SAT=0, ADD a=F0 b=20 -> sum=10 carry=1 ovf=0, out_valid 2 cycles after accept.
- ADD a=7F b=01 -> SAT=0: sum=80 ovf=1 carry=0; SAT=1: sum=7F ovf=1.
- SUB a=05 b=07 -> sum=FE carry=1 ovf=0.
- SUB a=80 b=01 -> SAT=1: sum=80 ovf=1.
- CLR a=03, ACC a=04, ACC a=05 back-to-back -> sums 03, 07, 0C with acc_cnt 1, 2, 3.
- Following ADD 01+01 -> sum=02, acc_cnt=3.
- out_ready=0 for 5 cycles with in_valid=1 on 4 beats -> exactly 2 accepted, then in_ready=0, outputs held stable.
- Release out_ready -> all 4 results emitted in order, none lost or duplicated.
- Both stages full, reset pulsed low mid-cycle -> out_valid=0 and acc_cnt=0 immediately (asynchronous).
- After release, ACC a=01 -> sum=01, acc_cnt=1.
